// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin, burst-bounded sharing of an async FIFO write port
//               among NUM_REQ valid/ready requesters. Optional per-requester
//               accepted-word counters enabled by macro FIFO_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int data_size = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*data_size-1:0]  req_data_i,
    input  logic                          write_full_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [data_size-1:0]          write_data_o,
    output logic                          write_increment_o,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          busy_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         stat_count_o
`endif
);

    localparam int c_CNT_W = 4;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     owner_q;
    logic [ID_W-1:0]     last_q;
    logic [c_CNT_W-1:0]  burst_q;
    logic                busy_q;

    logic                w_grant;
    logic                w_owner_valid;
    logic                w_accept;
    logic [ID_W-1:0]     w_winner;
    logic [data_size-1:0] w_data;

    // First valid requester strictly after the previous owner, wrapping.
    function automatic logic [ID_W-1:0] pick_next(input logic [NUM_REQ-1:0] valid,
                                                  input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] sel;
        logic            found;
        int              idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && valid[idx]) begin
                sel   = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_grant       = (state_q == ST_GRANT);
    assign w_owner_valid = req_valid_i[owner_q];
    assign w_accept      = w_grant & w_owner_valid & ~write_full_i;
    assign w_winner      = pick_next(req_valid_i, last_q);

    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant && (owner_q == ID_W'(k))) begin
                w_data = req_data_i[k*data_size +: data_size];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            burst_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        owner_q <= w_winner;
                        burst_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A dropped valid releases even while the FIFO is full.
                    if (!w_owner_valid) begin
                        last_q  <= owner_q;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!write_full_i) begin
                        if (burst_q == c_LAST_BEAT) begin
                            last_q  <= owner_q;
                            busy_q  <= 1'b0;
                            burst_q <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            burst_q <= burst_q + 1'b1;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o       = (w_grant && !write_full_i) ? (NUM_REQ'(1) << owner_q) : '0;
    assign write_increment_o = w_accept;
    assign write_data_o      = w_data;
    assign grant_id_o        = owner_q;
    assign busy_o            = busy_q;

`ifdef FIFO_ARB_STATS_EN
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_stats
            logic [15:0] cnt_q;
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    cnt_q <= '0;
                end else if (w_accept && (owner_q == ID_W'(k))) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
            assign stat_count_o[k*16 +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed scoreboard bench for fifo_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        write_full;
    logic [3:0]  req_ready_o;
    logic [7:0]  write_data_o;
    logic        write_increment_o;
    logic [1:0]  grant_id_o;
    logic        busy_o;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] stat_count_o;
`endif

    fifo_write_arbiter #(
        .data_size(8), .NUM_REQ(4), .MAX_BURST(4), .ID_W(2)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .req_valid_i       (req_valid),
        .req_data_i        (req_data),
        .write_full_i      (write_full),
        .req_ready_o       (req_ready_o),
        .write_data_o      (write_data_o),
        .write_increment_o (write_increment_o),
        .grant_id_o        (grant_id_o),
        .busy_o            (busy_o)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_count_o      (stat_count_o)
`endif
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [7:0] src_q [4][$];

    int checks = 0;
    int errors = 0;

    logic       s_incr, s_busy;
    logic [3:0] s_ready;
    logic [3:0] fire;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every presented FIFO write is matched against the queue.
    always @(negedge clk) begin
        if (reset_n && write_increment_o) begin
            checks++;
            if (write_full) begin
                errors++;
                $display("FAIL push_while_full got write_increment=1 expected 0");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_push got id=%0d data=%02h expected none", grant_id_o, write_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (write_data_o !== mon_e.data || grant_id_o !== mon_e.id) begin
                    errors++;
                    $display("FAIL push got id=%0d data=%02h expected id=%0d data=%02h",
                             grant_id_o, write_data_o, mon_e.id, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            req_valid[k] = (src_q[k].size() > 0);
            req_data[k*8 +: 8] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
        end
    endtask

    // One clock window: sample at negedge, complete handshakes at posedge.
    task automatic step();
        @(negedge clk);
        s_incr  = write_increment_o;
        s_busy  = busy_o;
        s_ready = req_ready_o;
        fire    = req_valid & req_ready_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (fire[k]) void'(src_q[k].pop_front());
        end
        drive();
    endtask

    task automatic run_pat(input int n, input logic [15:0] exp_incr,
                           input logic [15:0] exp_busy, input string name);
        logic [15:0] gi, gb;
        gi = '0;
        gb = '0;
        for (int i = 0; i < n; i++) begin
            step();
            gi[i] = s_incr;
            gb[i] = s_busy;
        end
        chk({name, "_incr"}, 32'(gi), 32'(exp_incr));
        chk({name, "_busy"}, 32'(gb), 32'(exp_busy));
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic clear_src();
        for (int k = 0; k < 4; k++) src_q[k].delete();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        write_full = 1'b0;
        clear_src();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        reset_n    = 1'b0;
        write_full = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_outputs", 32'({s_incr, s_busy, s_ready, grant_id_o, write_data_o}), 32'h0);
        end

        // Single requester, 6 words, burst split 4+2
        for (int b = 0; b < 6; b++) begin
            src_q[1].push_back(8'hA0 + 8'(b));
            push_exp(2'd1, 8'hA0 + 8'(b));
        end
        drive();
        run_pat(10, 16'h00DE, 16'h01DE, "single_req");

        // All four continuously valid: 0,1,2,3,0,... four beats each
        do_reset();
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 8; b++) src_q[k].push_back(8'(k*16 + b));
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                for (int b = 0; b < 4; b++) push_exp(2'(k), 8'(k*16 + r*4 + b));
        drive();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_incr) cnt++;
        end
        chk("pulses_per_20", 32'(cnt), 32'd16);
        for (int i = 0; i < 20; i++) step();
        chk("rr_drained", 32'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 32'd0);
`ifdef FIFO_ARB_STATS_EN
        for (int k = 0; k < 4; k++) chk("stat_after_rr", 32'(stat_count_o[k*16 +: 16]), 32'd8);
`endif

        // FIFO full stalls a req 0 burst after beat 2
        for (int b = 0; b < 4; b++) begin
            src_q[0].push_back(8'hC0 + 8'(b));
            push_exp(2'd0, 8'hC0 + 8'(b));
        end
        drive();
        run_pat(3, 16'h0006, 16'h0006, "pre_stall");
        write_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall", 32'({s_incr, s_busy, s_ready}), 32'({1'b0, 1'b1, 4'b0000}));
        end
        write_full = 1'b0;
        run_pat(3, 16'h0003, 16'h0003, "post_stall");

        // Owner drops valid after one beat; rotation continues 2 -> 3 -> 0
        src_q[2].push_back(8'hD0);
        src_q[3].push_back(8'hD1);
        src_q[0].push_back(8'hD2);
        push_exp(2'd2, 8'hD0);
        push_exp(2'd3, 8'hD1);
        push_exp(2'd0, 8'hD2);
        drive();
        run_pat(10, 16'h0092, 16'h01B6, "drop_valid");

        // Reset in the middle of a req 1 burst, on beat 2
        for (int b = 0; b < 4; b++) src_q[1].push_back(8'hE0 + 8'(b));
        push_exp(2'd1, 8'hE0);
        push_exp(2'd1, 8'hE1);
        drive();
        step();
        step();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", 32'({write_increment_o, busy_o, req_ready_o, grant_id_o, write_data_o}), 32'h0);
        clear_src();
        drive();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
`ifdef FIFO_ARB_STATS_EN
        for (int k = 0; k < 4; k++) chk("stat_after_reset", 32'(stat_count_o[k*16 +: 16]), 32'd0);
`endif
        src_q[0].push_back(8'hF0);
        src_q[1].push_back(8'hF1);
        push_exp(2'd0, 8'hF0);
        push_exp(2'd1, 8'hF1);
        drive();
        run_pat(7, 16'h0012, 16'h0036, "post_reset");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
